// File: rtl/clk_div_rst_gen.sv
// Multi-channel clock-enable divider with per-channel sequenced active-low resets.
// Divisors and enables are programmed over a req/ack register port.
//
// cfg state | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for cfg_req_i; write/read capture happens on exit
// S_ACK     | cfg_ack_o high for exactly one cycle, then back to idle
module clk_div_rst_gen #(
  parameter int NUM_CH     = 2,
  parameter int DIV_W      = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_mode_i,
  input  logic              cfg_req_i,
  input  logic              cfg_wrn_i,
  input  logic [3:0]        cfg_add_i,
  input  logic [31:0]       cfg_data_i,
  output logic              cfg_ack_o,
  output logic [31:0]       cfg_r_data_o,
  output logic [NUM_CH-1:0] clk_en_o,
  output logic [NUM_CH-1:0] div_clk_o,
  output logic [NUM_CH-1:0] lock_o,
  output logic [NUM_CH-1:0] rstn_o
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } cfg_state_t;

  cfg_state_t r_state;
  cfg_state_t w_state_nxt;
  logic       w_take;
  logic       w_wr;
  logic       w_unused_data;

  logic [NUM_CH-1:0] r_ctrl;
  logic [NUM_CH-1:0] r_ctrl_d;
  logic [DIV_W-1:0]  r_div_sh [NUM_CH];
  logic [31:0]       r_rdata;
  logic [31:0]       w_rdata;

  logic [NUM_CH-1:0] w_clk_en;
  logic [NUM_CH-1:0] w_div_clk;
  logic [NUM_CH-1:0] w_lock;
  logic [NUM_CH-1:0] w_rstn;

  assign w_unused_data = ^cfg_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_req_i) begin
          w_take      = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wr = w_take & ~cfg_wrn_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl   <= '1;
      r_ctrl_d <= '1;
    end else begin
      r_ctrl_d <= r_ctrl;
      if (w_wr && cfg_add_i == 4'd0) r_ctrl <= cfg_data_i[NUM_CH-1:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (cfg_add_i == 4'd0)      w_rdata = 32'(r_ctrl);
    else if (cfg_add_i == 4'd1) w_rdata = 32'(w_lock);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (cfg_add_i == 4'(ch + 2)) w_rdata = 32'(r_div_sh[ch]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       r_rdata <= '0;
    else if (w_take) r_rdata <= cfg_wrn_i ? w_rdata : 32'd0;
  end

  assign cfg_ack_o    = (r_state == S_ACK);
  assign cfg_r_data_o = cfg_ack_o ? r_rdata : 32'd0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_dact;
    logic [RC_W-1:0]  r_rst_cnt;
    logic             r_clk_en;
    logic             r_div_clk;
    logic             r_lock;
    logic             r_rstn;
    logic             w_wrap;

    always_ff @(posedge clk_i) begin
      if (rst_i)                                r_div_sh[g] <= DIV_W'(1);
      else if (w_wr && cfg_add_i == 4'(g + 2))  r_div_sh[g] <= cfg_data_i[DIV_W-1:0];
    end

    // A zero divisor never matches, so the channel stalls until re-enabled.
    assign w_wrap = (r_dact != '0) && (r_cnt == r_dact - DIV_W'(1));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt     <= '0;
        r_dact    <= DIV_W'(1);
        r_rst_cnt <= '0;
        r_clk_en  <= 1'b0;
        r_div_clk <= 1'b0;
        r_lock    <= 1'b0;
        r_rstn    <= 1'b0;
      end else if (!r_ctrl[g]) begin
        r_cnt     <= '0;
        r_rst_cnt <= '0;
        r_clk_en  <= 1'b0;
        r_div_clk <= 1'b0;
        r_lock    <= 1'b0;
        r_rstn    <= 1'b0;
      end else if (!r_ctrl_d[g]) begin
        r_dact   <= r_div_sh[g];
        r_cnt    <= '0;
        r_clk_en <= 1'b0;
      end else begin
        r_clk_en <= w_wrap;
        r_rstn   <= (r_rst_cnt == RC_W'(RST_CYCLES));
        if (w_wrap) begin
          r_cnt     <= '0;
          r_dact    <= r_div_sh[g];
          r_div_clk <= ~r_div_clk;
          r_lock    <= 1'b1;
          if (r_rst_cnt != RC_W'(RST_CYCLES)) r_rst_cnt <= r_rst_cnt + RC_W'(1);
        end else if (r_dact != '0) begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end
    end

    assign w_clk_en[g]  = r_clk_en;
    assign w_div_clk[g] = r_div_clk;
    assign w_lock[g]    = r_lock;
    assign w_rstn[g]    = r_rstn;
  end

  assign clk_en_o  = test_mode_i ? {NUM_CH{1'b1}} : w_clk_en;
  assign rstn_o    = test_mode_i ? {NUM_CH{~rst_i}} : w_rstn;
  assign div_clk_o = w_div_clk;
  assign lock_o    = w_lock;

endmodule

// File: tb/tb_clk_div_rst_gen.sv
// Directed bench for clk_div_rst_gen: reset sequencing, divider reprogramming,
// channel disable/enable, register port handshake, test-mode bypass, mid-ACK reset.
module tb_clk_div_rst_gen;

  localparam int NUM_CH     = 2;
  localparam int DIV_W      = 8;
  localparam int RST_CYCLES = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              test_mode_i;
  logic              cfg_req_i;
  logic              cfg_wrn_i;
  logic [3:0]        cfg_add_i;
  logic [31:0]       cfg_data_i;
  logic              cfg_ack_o;
  logic [31:0]       cfg_r_data_o;
  logic [NUM_CH-1:0] clk_en_o;
  logic [NUM_CH-1:0] div_clk_o;
  logic [NUM_CH-1:0] lock_o;
  logic [NUM_CH-1:0] rstn_o;

  clk_div_rst_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .test_mode_i(test_mode_i),
    .cfg_req_i(cfg_req_i), .cfg_wrn_i(cfg_wrn_i), .cfg_add_i(cfg_add_i),
    .cfg_data_i(cfg_data_i), .cfg_ack_o(cfg_ack_o), .cfg_r_data_o(cfg_r_data_o),
    .clk_en_o(clk_en_o), .div_clk_o(div_clk_o), .lock_o(lock_o), .rstn_o(rstn_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = -1;

  logic [NUM_CH-1:0] hist_en   [128];
  logic [NUM_CH-1:0] hist_dc   [128];
  logic [NUM_CH-1:0] hist_lock [128];
  logic [NUM_CH-1:0] hist_rstn [128];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    if (cyc >= 0 && cyc < 128) begin
      hist_en[cyc]   = clk_en_o;
      hist_dc[cyc]   = div_clk_o;
      hist_lock[cyc] = lock_o;
      hist_rstn[cyc] = rstn_o;
    end
  endtask

  task automatic cfg_xfer(input logic wrn, input logic [3:0] add, input logic [31:0] data,
                          output logic [31:0] rd);
    cfg_req_i  = 1'b1;
    cfg_wrn_i  = wrn;
    cfg_add_i  = add;
    cfg_data_i = data;
    tick();
    chk("ack_high", 32'(cfg_ack_o), 32'd1);
    rd = cfg_r_data_o;
    cfg_req_i = 1'b0;
    tick();
    chk("ack_low", 32'(cfg_ack_o), 32'd0);
    chk("rdata_idle", cfg_r_data_o, 32'd0);
  endtask

  // Expected channel-0 clk_en / div_clk after edges 6..16 (DIV[0]=3 written at edge 6)
  logic exp_en0 [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic exp_dc0 [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] rd;
    logic        b1;

    rst_i = 1'b1; test_mode_i = 1'b0;
    cfg_req_i = 1'b0; cfg_wrn_i = 1'b0; cfg_add_i = '0; cfg_data_i = '0;

    // edge 0: reset
    tick();
    chk("rst_clk_en", 32'(clk_en_o), 32'd0);
    chk("rst_lock", 32'(lock_o), 32'd0);
    chk("rst_rstn", 32'(rstn_o), 32'd0);
    chk("rst_ack", 32'(cfg_ack_o), 32'd0);
    chk("rst_divclk", 32'(div_clk_o), 32'd0);
    rst_i = 1'b0;

    tick(); // edge 1
    chk("e1_clk_en", 32'(clk_en_o), 32'd3);
    chk("e1_lock", 32'(lock_o), 32'd3);
    chk("e1_rstn", 32'(rstn_o), 32'd0);
    chk("e1_divclk", 32'(div_clk_o), 32'd3);
    while (cyc < 4) tick();
    chk("e4_rstn", 32'(rstn_o), 32'd0);
    tick(); // edge 5
    chk("e5_rstn", 32'(rstn_o), 32'd3);

    // DIV[0] = 3 sampled at edge 6, readback sampled at edge 8
    cfg_xfer(1'b0, 4'd2, 32'd3, rd);
    cfg_xfer(1'b1, 4'd2, 32'd0, rd);
    chk("rd_div0", rd, 32'd3);
    while (cyc < 16) tick();
    for (int i = 0; i < 11; i++) begin
      b1 = ((i + 6) % 2) == 1;
      chk($sformatf("en_e%0d", i + 6), 32'(hist_en[i+6]), 32'({1'b1, exp_en0[i]}));
      chk($sformatf("dc_e%0d", i + 6), 32'(hist_dc[i+6]), 32'({b1, exp_dc0[i]}));
    end

    // Disable channel 0 (CTRL sampled at edge 17, channel clears at edge 18)
    cfg_xfer(1'b0, 4'd0, 32'h2, rd);
    chk("dis_lock", 32'(lock_o), 32'd2);
    chk("dis_rstn", 32'(rstn_o), 32'd2);
    chk("dis_clk_en0", 32'(clk_en_o[0]), 32'd0);
    chk("dis_divclk0", 32'(div_clk_o[0]), 32'd0);
    cfg_xfer(1'b1, 4'd1, 32'd0, rd);
    chk("rd_status_dis", rd, 32'd2);

    // Re-enable (sampled edge 21, load at 22, wraps 25/28/31/34, rstn at 35)
    cfg_xfer(1'b0, 4'd0, 32'h3, rd);
    while (cyc < 35) tick();
    chk("en_e24", 32'(hist_en[24][0]), 32'd0);
    chk("en_e25", 32'(hist_en[25][0]), 32'd1);
    chk("lock_e24", 32'(hist_lock[24][0]), 32'd0);
    chk("lock_e25", 32'(hist_lock[25][0]), 32'd1);
    chk("rstn_e34", 32'(hist_rstn[34]), 32'd2);
    chk("rstn_e35", 32'(hist_rstn[35]), 32'd3);

    // Unmapped address
    cfg_xfer(1'b1, 4'hF, 32'd0, rd);
    chk("rd_0xF", rd, 32'd0);
    cfg_xfer(1'b0, 4'hF, 32'hFFFF_FFFF, rd);
    cfg_xfer(1'b1, 4'd0, 32'd0, rd);
    chk("rd_ctrl", rd, 32'd3);
    cfg_xfer(1'b1, 4'd2, 32'd0, rd);
    chk("rd_div0_kept", rd, 32'd3);
    cfg_xfer(1'b1, 4'd3, 32'd0, rd);
    chk("rd_div1_kept", rd, 32'd1);

    // Held request: ack every other cycle
    cfg_req_i = 1'b1; cfg_wrn_i = 1'b1; cfg_add_i = 4'd1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("held_ack%0d", i), 32'(cfg_ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk($sformatf("held_rd%0d", i), cfg_r_data_o, 32'd3);
    end
    cfg_req_i = 1'b0;
    tick();
    chk("held_release", 32'(cfg_ack_o), 32'd0);

    // Test-mode bypass
    test_mode_i = 1'b1;
    #1;
    chk("tm_rstn_hi", 32'(rstn_o), 32'd3);
    chk("tm_en", 32'(clk_en_o), 32'd3);
    rst_i = 1'b1;
    #1;
    chk("tm_rstn_comb", 32'(rstn_o), 32'd0);
    tick();
    chk("tm_en_rst", 32'(clk_en_o), 32'd3);
    chk("tm_rstn_rst", 32'(rstn_o), 32'd0);
    rst_i = 1'b0;
    #1;
    chk("tm_rstn_rel", 32'(rstn_o), 32'd3);
    test_mode_i = 1'b0;
    #1;
    chk("post_tm_rstn", 32'(rstn_o), 32'd0);
    chk("post_tm_en", 32'(clk_en_o), 32'd0);
    tick();
    chk("rel2_e1_en", 32'(clk_en_o), 32'd3);
    chk("rel2_e1_lock", 32'(lock_o), 32'd3);
    tick(); tick(); tick();
    chk("rel2_e4_rstn", 32'(rstn_o), 32'd0);
    tick();
    chk("rel2_e5_rstn", 32'(rstn_o), 32'd3);

    // Reset during ACK with DIV[0] = 5
    cfg_xfer(1'b0, 4'd2, 32'd5, rd);
    cfg_req_i = 1'b1; cfg_wrn_i = 1'b1; cfg_add_i = 4'd2;
    tick();
    chk("abort_ack_hi", 32'(cfg_ack_o), 32'd1);
    chk("abort_rd", cfg_r_data_o, 32'd5);
    rst_i = 1'b1;
    cfg_req_i = 1'b0;
    tick();
    chk("abort_ack", 32'(cfg_ack_o), 32'd0);
    chk("abort_rdata", cfg_r_data_o, 32'd0);
    chk("abort_rstn", 32'(rstn_o), 32'd0);
    chk("abort_lock", 32'(lock_o), 32'd0);
    rst_i = 1'b0;
    cfg_xfer(1'b1, 4'd2, 32'd0, rd);
    chk("post_rst_div0", rd, 32'd1);
    cfg_xfer(1'b1, 4'd0, 32'd0, rd);
    chk("post_rst_ctrl", rd, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
